// File: rtl/mcm_coord_tx.sv
// MCM coordinate link transmitter: on an iRQ rising edge it streams a BYTES-long frame
// from a sync-read buffer, one byte per oVal pulse. Define MCM_TX_CHECKSUM_EN to append a sum byte.
module mcm_coord_tx #(
  parameter int BYTES    = 144,
  parameter int VAL_HIGH = 4,
  parameter int VAL_LOW  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRQ,
  output logic [7:0] oRdAddr,
  output logic       oRdEn,
  input  logic [7:0] iRdData,
  output logic [7:0] oData,
  output logic       oVal,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, HIGH, LOW} state_t;

  localparam logic [7:0] HI_RLD = 8'(VAL_HIGH - 1);
  localparam logic [7:0] LO_RLD = 8'(VAL_LOW - 1);
  localparam logic [7:0] PAY_END = 8'(BYTES);
`ifdef MCM_TX_CHECKSUM_EN
  localparam logic [7:0] LAST_IDX = 8'(BYTES);
`else
  localparam logic [7:0] LAST_IDX = 8'(BYTES - 1);
`endif

  state_t     state_q, state_d;
  logic       rq_prev_q, rq_prev_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] ph_q, ph_d;
  logic [7:0] addr_q, addr_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] data_q, data_d;
  logic       val_q, val_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       start;
  logic [7:0] idx_nxt;
`ifdef MCM_TX_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  assign start   = iRQ & ~rq_prev_q;
  assign idx_nxt = idx_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    rq_prev_d = iRQ;
    idx_d     = idx_q;
    ph_d      = ph_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    data_d    = data_q;
    val_d     = val_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef MCM_TX_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    // A start edge wins over everything: it opens a frame from IDLE or aborts a running one.
    if (start) begin
      state_d = FETCH;
      idx_d   = 8'd0;
      addr_d  = 8'd0;
      rd_en_d = 1'b1;
      val_d   = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
`ifdef MCM_TX_CHECKSUM_EN
      chk_d   = 8'd0;
`endif
    end else begin
      case (state_q)
        FETCH: state_d = LATCH;
        LATCH: begin
          state_d = HIGH;
          val_d   = 1'b1;
          ph_d    = HI_RLD;
`ifdef MCM_TX_CHECKSUM_EN
          if (idx_q == PAY_END) begin
            data_d = chk_q;
          end else begin
            data_d = iRdData;
            chk_d  = chk_q + iRdData;
          end
`else
          data_d = iRdData;
`endif
        end
        HIGH: begin
          if (ph_q == 8'd0) begin
            state_d = LOW;
            val_d   = 1'b0;
            ph_d    = LO_RLD;
          end else begin
            ph_d = ph_q - 8'd1;
          end
        end
        LOW: begin
          if (ph_q != 8'd0) begin
            ph_d = ph_q - 8'd1;
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = FETCH;
            idx_d   = idx_nxt;
            addr_d  = idx_nxt;
            // The checksum slot has no buffer entry behind it.
            rd_en_d = (idx_nxt != PAY_END);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rq_prev_q <= 1'b1;
      idx_q     <= 8'd0;
      ph_q      <= 8'd0;
      addr_q    <= 8'd0;
      rd_en_q   <= 1'b0;
      data_q    <= 8'd0;
      val_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MCM_TX_CHECKSUM_EN
      chk_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      rq_prev_q <= rq_prev_d;
      idx_q     <= idx_d;
      ph_q      <= ph_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      data_q    <= data_d;
      val_q     <= val_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MCM_TX_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign oRdAddr = addr_q;
  assign oRdEn   = rd_en_q;
  assign oData   = data_q;
  assign oVal    = val_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;

endmodule

// File: tb/tb_mcm_coord_tx.sv
// Scoreboard bench for mcm_coord_tx: frames expected from a buffer-content model,
// checked by a negedge monitor on read strobes, oVal pulses and oDone.
module tb_mcm_coord_tx;
  localparam int BYTES = 144;
  localparam int VH    = 4;
  localparam int VL    = 4;
  localparam int PER   = 2 + VH + VL;
`ifdef MCM_TX_CHECKSUM_EN
  localparam int NPULSE = BYTES + 1;
`else
  localparam int NPULSE = BYTES;
`endif

  typedef struct { int d; int c; } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iRQ = 1'b1;
  logic [7:0] oRdAddr, oData, rd_data;
  logic       oRdEn, oVal, oBusy, oDone;

  logic [7:0] mem [0:255];
  exp_t pq[$], aq[$];
  int   dq[$];
  int   cyc = 0, tests = 0, errors = 0, last_rise = 0;
  logic prev_val = 1'b0, prev_done = 1'b0, aborted = 1'b0;

  mcm_coord_tx #(.BYTES(BYTES), .VAL_HIGH(VH), .VAL_LOW(VL)) dut (
    .clk(clk), .reset(reset), .iRQ(iRQ), .oRdAddr(oRdAddr), .oRdEn(oRdEn),
    .iRdData(rd_data), .oData(oData), .oVal(oVal), .oBusy(oBusy), .oDone(oDone));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (oRdEn) rd_data <= mem[oRdAddr];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: byte k is fetched at E+k*PER, shown from E+k*PER+2; done after all pulses.
  task automatic push_frame(input int e);
    logic [7:0] sum = 8'd0;
    for (int k = 0; k < BYTES; k++) begin
      aq.push_back('{k, e + k * PER});
      pq.push_back('{int'(mem[k]), e + k * PER + 2});
      sum = sum + mem[k];
    end
`ifdef MCM_TX_CHECKSUM_EN
    pq.push_back('{int'(sum), e + BYTES * PER + 2});
`endif
    dq.push_back(e + NPULSE * PER);
  endtask

  task automatic flush();
    pq.delete(); aq.delete(); dq.delete();
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_rq(input int hold, output int e);
    tick();
    e = cyc + 1;
    iRQ = 1'b1;
    push_frame(e);
    repeat (hold) tick();
    iRQ = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((pq.size() != 0 || aq.size() != 0 || dq.size() != 0) && n < max) begin
      tick(); n++;
    end
    chk("frame_complete_in_time", int'(n < max), 1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (oRdEn) begin
      if (aq.size() == 0) chk("unexpected_rden", 1, 0);
      else begin
        e = aq.pop_front();
        chk("rd_addr", oRdAddr, e.d);
        chk("rd_time", cyc, e.c);
      end
    end
    if (oVal && !prev_val) begin
      last_rise = cyc;
      if (pq.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = pq.pop_front();
        chk("pulse_data", oData, e.d);
        chk("pulse_rise_time", cyc, e.c);
      end
    end
    if (!oVal && prev_val) begin
      if (aborted) aborted = 1'b0;
      else chk("high_width", cyc - last_rise, VH);
    end
    if (oDone && !prev_done) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_time", cyc, dq.pop_front());
      chk("busy_at_done", oBusy, 0);
    end
    prev_val  = oVal;
    prev_done = oDone;
  end

  initial begin
    int e1, e2, bad;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset with iRQ already high: no frame may start after release.
    repeat (3) tick();
    chk("reset_outputs", {oRdAddr, oRdEn, oData, oVal, oBusy, oDone}, 0);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if ({oRdAddr, oRdEn, oData, oVal, oBusy, oDone} != 0) bad = 1;
    end
    chk("idle_after_release_rq_high", bad, 0);
    iRQ = 1'b0;
    repeat (3) tick();

    // Ramp buffer, single-clock request.
    pulse_rq(1, e1);
    wait_idle(NPULSE * PER + 50);
    chk("done_sticky", oDone, 1);

    // Request held high: exactly one frame.
    fill_rand();
    pulse_rq(3000, e1);
    wait_idle(100);

    // Restart during the HIGH phase of byte 50.
    fill_rand();
    pulse_rq(1, e1);
    wait_cyc(e1 + 50 * PER + 3);
    flush();
    aborted = 1'b1;
    e2 = cyc + 1;
    iRQ = 1'b1;
    push_frame(e2);
    tick();
    iRQ = 1'b0;
    chk("abort_val_low", oVal, 0);
    chk("abort_addr_zero", oRdAddr, 0);
    chk("abort_done_low", oDone, 0);
    chk("abort_busy", oBusy, 1);
    wait_idle(NPULSE * PER + 50);

    // Async reset in the middle of a HIGH phase.
    fill_rand();
    pulse_rq(1, e1);
    wait_cyc(e1 + 20 * PER + 3);
    flush();
    aborted = 1'b1;
    reset = 1'b0;
    #1;
    chk("async_reset_val", oVal, 0);
    chk("async_reset_busy", oBusy, 0);
    repeat (3) tick();
    reset = 1'b1;
    bad = 0;
    repeat (60) begin
      tick();
      if (oVal || oRdEn || oBusy || oDone) bad = 1;
    end
    chk("idle_after_mid_reset", bad, 0);

`ifdef MCM_TX_CHECKSUM_EN
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    pulse_rq(1, e1);
    wait_idle(NPULSE * PER + 50);
    chk("checksum_ff_byte", oData, 8'h70);
`endif

    for (int f = 0; f < 2; f++) begin
      fill_rand();
      pulse_rq($urandom_range(1, 5), e1);
      wait_idle(NPULSE * PER + 50);
      repeat ($urandom_range(0, 20)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/mcm_coord_tx.md
# mcm_coord_tx

Transmit-side counterpart of the MCM coordinate receiver: on a request edge it reads a fixed-length frame (default 144 bytes) from a synchronous-read buffer and sends it byte by byte on an 8-bit data bus qualified by a slow `oVal` strobe. The pulse widths are sized so the receiver's double-flop synchronizer and edge detector catch every byte. The block sits on the MCM/bench side and drives the coordinate link toward the receiver.

## Interface
- `BYTES`, 144: payload bytes per frame; 1..254.
- `VAL_HIGH`, 4: clocks `oVal` is held high per byte; 2..255.
- `VAL_LOW`, 4: clocks `oVal` is held low after each byte; 2..255.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `iRQ`  in  1  frame request, synchronous to `clk`; a rising edge starts or restarts a frame.
- `oRdAddr`  out  8  buffer read address (byte index).
- `oRdEn`  out  1  buffer read enable, one clock per payload byte.
- `iRdData`  in  8  buffer read data, valid the clock after `oRdEn`.
- `oData`  out  8  byte on the link; stable for the byte's full HIGH and LOW phases.
- `oVal`  out  1  byte strobe toward the receiver.
- `oBusy`  out  1  frame in progress.
- `oDone`  out  1  sticky "frame sent"; cleared by the next start.

## Operation
- Outputs after reset: `oRdAddr`=0, `oRdEn`=0, `oData`=0, `oVal`=0, `oBusy`=0, `oDone`=0. FSM resets to IDLE, byte counter to 0, checksum to 0.
- Request edge register `rqPrev` resets to 1, so `iRQ` already high at reset release does not start a frame. Start = `iRQ & !rqPrev` sampled at a clock edge.
- States:
  - IDLE: on start, go to FETCH with index=0. Clear `oDone`, clear checksum, set `oBusy`.
  - FETCH, 1 clk: `oRdAddr`=index, `oRdEn`=1 for payload bytes. Go to LATCH.
  - LATCH, 1 clk: `oData` <= `iRdData`; checksum <= checksum + `iRdData` (mod 256). Go to HIGH.
  - HIGH, `VAL_HIGH` clks: `oVal`=1. Go to LOW.
  - LOW, `VAL_LOW` clks: `oVal`=0. If index = last, set `oDone`, clear `oBusy`, go to IDLE. Otherwise index+1 and go to FETCH.
- All outputs are registered. `oVal` changes only on HIGH entry and exit.
- Phase counter: 8 bits, reloaded on each phase entry.
- Index counter: 8 bits, never wraps within a frame. Last index = `BYTES`-1, or `BYTES` when the checksum byte is compiled in.
- Start seen in any non-IDLE state aborts the frame and restarts it:
  - `oVal` drops at that same edge.
  - State goes to FETCH with index=0 and checksum cleared.
  - `oDone` stays 0.
- `iRQ` held high produces exactly one frame.
- Async reset mid-frame forces all reset values immediately, including `oVal`=0.

## Timing
- Start edge E: FETCH at E, LATCH at E+1, `oVal` rises at E+2 and falls at E+2+`VAL_HIGH`.
- Per byte: 2+`VAL_HIGH`+`VAL_LOW` clks (10 at defaults).
- `oDone` rises at E + N·(2+`VAL_HIGH`+`VAL_LOW`), where N = number of bytes sent. At defaults this is E+1440.
- `oRdEn` high at E + k·10 for byte k. `oRdAddr`=k over the same clock.
- `oData` for byte k updates at E+k·10+2 and holds until the next LATCH.

## Configuration
- `MCM_TX_CHECKSUM_EN` defined:
  - One extra byte follows the payload at index `BYTES`, with the same FETCH/LATCH/HIGH/LOW timing.
  - `oRdEn` stays low during that byte's FETCH.
  - `oData` = 8-bit sum mod 256 of all payload bytes.
  - Frame = `BYTES`+1 pulses; `oDone` rises one byte period later.
- Not defined: no checksum logic; the frame is exactly `BYTES` pulses.

## Test plan
- Reset, no request: all outputs 0 for 100 clks. Release reset with `iRQ`=1: no frame starts.
- Defaults, buffer[i]=i, one `iRQ` pulse: 144 `oVal` pulses, each 4 high / 4 low.
  - `oData`=k during pulse k; `oRdAddr` 0..143.
  - `oVal` first rises at E+2; `oDone`=1 at E+1440; `oBusy` low at the same edge.
- Second `iRQ` edge during byte 50: `oVal` low at that edge, `oRdAddr` back to 0, `oDone` stays 0, `oDone` rises at E2+1440.
- `iRQ` held high for 3000 clks: exactly 144 pulses.
- `reset` asserted during a HIGH phase: `oVal`=0 and `oBusy`=0 immediately; after release, no activity until a new `iRQ` rising edge.
- `MCM_TX_CHECKSUM_EN`, buffer all 0xFF: 145 pulses, last `oData`=0x70, `oDone` at E+1450. With `VAL_HIGH`=`VAL_LOW`=2, byte period is 6.
